// File: rtl/piso_bit_feeder_pkg.sv
// piso_bit_feeder_pkg: shared state encoding, sizing helper and default width for the serialiser.
package piso_bit_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder: valid/ready word intake, one registered bit per clock to the 1101 detector.
module piso_bit_feeder
    import piso_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("piso_bit_feeder: WIDTH must be in 2..32");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             shifting;
    logic             last;
    logic             xfer;

    assign shifting   = (state_q == SHIFT);
    assign last       = shifting && (cnt_q == LAST);
    assign din_ready  = !shifting || last;
    assign xfer       = din_valid && din_ready;
    assign busy       = shifting;
    assign frame_done = last;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;

    // The shift register keeps the next bit at the send end, so each edge only moves it by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
        end else if (xfer) begin
            sout_q       <= MSB_FIRST ? din[WIDTH-1] : din[0];
            sr_q         <= MSB_FIRST ? (din << 1) : (din >> 1);
            cnt_q        <= '0;
            sout_valid_q <= 1'b1;
            state_q      <= SHIFT;
        end else if (shifting && !last) begin
            sout_q       <= MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
            sr_q         <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            cnt_q        <= cnt_q + CNT_W'(1);
        end else begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// tb_piso_bit_feeder: directed checks of the serialiser in MSB-first and LSB-first builds.
module tb_piso_bit_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din2;
    logic       din_valid, din_valid2;
    logic       din_ready, sout, sout_valid, busy, frame_done;
    logic       din_ready2, sout2, sout_valid2, busy2, frame_done2;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .busy(busy), .frame_done(frame_done)
    );

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
        .sout(sout2), .sout_valid(sout_valid2), .busy(busy2), .frame_done(frame_done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sout"}, 32'(sout), 32'd0);
        chk({tag, "_valid"}, 32'(sout_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    // Sends w0 (and w1 back-to-back when n==2) on the MSB-first unit and checks every serial cycle.
    task automatic run_words(input string tag, input logic [7:0] w0, input logic [7:0] w1, input int n);
        logic [7:0] w;
        din = w0;
        din_valid = 1'b1;
        chk({tag, "_ready_idle"}, 32'(din_ready), 32'd1);
        tick();
        if (n > 1) din = w1;
        else din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("%s_w%0d_b%0d", tag, i, k), 32'(sout), 32'(w[7-k]));
                chk($sformatf("%s_w%0d_v%0d", tag, i, k), 32'(sout_valid), 32'd1);
                chk($sformatf("%s_w%0d_fd%0d", tag, i, k), 32'(frame_done), 32'(k == 7));
                chk($sformatf("%s_w%0d_rdy%0d", tag, i, k), 32'(din_ready), 32'(k == 7));
                if (i == 0 && k == 7 && n > 1) begin
                    tick();
                    din_valid = 1'b0;
                end else begin
                    tick();
                end
            end
        end
        chk_idle({tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_lsb;
        rst = 1'b1;
        din = '0;
        din2 = '0;
        din_valid = 1'b0;
        din_valid2 = 1'b0;
        repeat (3) tick();
        chk_idle("in_reset");
        rst = 1'b0;
        tick();
        chk_idle("post_reset");
        chk("post_reset_ready", 32'(din_ready), 32'd1);

        run_words("single_d0", 8'hD0, 8'h00, 1);
        run_words("b2b_0d", 8'h0D, 8'h0D, 2);
        run_words("straddle", 8'h01, 8'hA0, 2);

        // LSB-first build: 8'h0B leaves as 1,1,0,1,0,0,0,0.
        exp_lsb = 8'b1101_0000;
        din2 = 8'h0B;
        din_valid2 = 1'b1;
        tick();
        din_valid2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb_b%0d", k), 32'(sout2), 32'(exp_lsb[7-k]));
            chk($sformatf("lsb_v%0d", k), 32'(sout_valid2), 32'd1);
            tick();
        end
        chk("lsb_after_valid", 32'(sout_valid2), 32'd0);

        // Backpressure: 8'hFF offered during bit 2 of 8'hA5 must wait for the last bit.
        din = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                din = 8'hFF;
                din_valid = 1'b1;
            end
            chk($sformatf("bp_a5_b%0d", k), 32'(sout), 32'(k == 0 || k == 2 || k == 5 || k == 7));
            chk($sformatf("bp_rdy%0d", k), 32'(din_ready), 32'(k == 7));
            tick();
        end
        din_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_ff_b%0d", k), 32'(sout), 32'd1);
            chk($sformatf("bp_ff_v%0d", k), 32'(sout_valid), 32'd1);
            tick();
        end
        chk_idle("bp_after");

        // Asynchronous reset mid-word clears outputs without a clock edge.
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        chk("midrst_sout_before", 32'(sout), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        chk("midrst_ready", 32'(din_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk_idle("midrst_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
